// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box, round constants, and the
// state encoding of the inverse key-schedule walker.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 and entries above NR are padding so a 4-bit round index never
    // selects outside the table.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_inv_keyexp_if.sv
// Request/response bundle between key storage, the inverse key-schedule
// walker and the inverse-cipher round datapath.
interface aes_inv_keyexp_if;
  logic         start_i;
  logic [127:0] key_last_i;
  logic         out_ready_i;
  logic         out_valid_o;
  logic [127:0] key_round_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, key_last_i, out_ready_i,
    input  out_valid_o, key_round_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, key_last_i, out_ready_i,
    output out_valid_o, key_round_o, round_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_subword.sv
// Four parallel forward S-box lookups on a 32-bit word; purely combinational,
// shared by the forward and inverse key schedules.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign dout[gi*8 +: 8] = SBOX[din[gi*8 +: 8]];
    end
  endgenerate

endmodule

// File: rtl/aes_inv_keyexp.sv
// Walks the AES-128 key schedule backwards from the round-10 key, emitting
// round keys 10..0 one per accepted handshake.
module aes_inv_keyexp
  import aes_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n,
  aes_inv_keyexp_if.slave         bus
);

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   rnd_reg, rnd_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  sub_in, sub_out;
  logic [127:0] key_prev;

  assign {w0, w1, w2, w3} = key_reg;

  // Undo the forward word chain first; the recovered w3 feeds the g-function.
  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign sub_in = {p3[23:0], p3[31:24]};

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  assign p0       = w0 ^ sub_out ^ {RCON[rnd_reg], 24'h0};
  assign key_prev = {p0, p1, p2, p3};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      rnd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      rnd_reg   <= rnd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    rnd_next   = rnd_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          key_next   = bus.key_last_i;
          rnd_next   = NR;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready_i) begin
          if (rnd_reg != 4'd0) begin
            key_next = key_prev;
            rnd_next = rnd_reg - 4'd1;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, gated to zero when idle.
  assign bus.out_valid_o = (state_reg == EMIT);
  assign bus.key_round_o = bus.out_valid_o ? key_reg : '0;
  assign bus.round_o     = bus.out_valid_o ? rnd_reg : '0;
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.done_o      = (state_reg == DONE);

endmodule

// File: tb/tb_aes_inv_keyexp.sv
// Directed bench for the inverse AES-128 key-schedule walker with an
// independently derived S-box and forward key expansion as reference.
module tb_aes_inv_keyexp;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  aes_inv_keyexp_if kif ();

  aes_inv_keyexp dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (kif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) inverse plus affine transform.
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  logic [127:0] exp_rk [11];

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  logic [127:0] got_key [11];
  logic [3:0]   got_rnd [11];
  int           n_got;

  // mode 0: ready high, 1: random ready, 2: start pulse at round 6, 3: reset at round 4
  task automatic run_walk(input logic [127:0] k, input int mode);
    bit           held, fin, pulsed;
    logic [127:0] hk;
    logic [3:0]   hr;
    int           cyc;
    held = 0; fin = 0; pulsed = 0; cyc = 0; n_got = 0;
    kif.start_i     = 1'b1;
    kif.key_last_i  = k;
    kif.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    kif.start_i    = 1'b0;
    kif.key_last_i = '0;
    chk("latency_valid", 128'(kif.out_valid_o), 128'd1);
    chk("latency_round", 128'(kif.round_o), 128'd10);
    while (!fin && cyc < 400) begin
      if (held) begin
        chk("hold_key", kif.key_round_o, hk);
        chk("hold_round", 128'(kif.round_o), 128'(hr));
        held = 0;
      end
      kif.out_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && kif.out_valid_o && kif.round_o == 4'd6 && !pulsed) begin
        kif.start_i    = 1'b1;
        kif.key_last_i = '0;
        pulsed         = 1;
      end
      if (mode == 3 && kif.out_valid_o && kif.round_o == 4'd4) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 128'(kif.out_valid_o), 128'd0);
        chk("rst_key", kif.key_round_o, 128'd0);
        chk("rst_round", 128'(kif.round_o), 128'd0);
        chk("rst_busy", 128'(kif.busy_o), 128'd0);
        chk("rst_done", 128'(kif.done_o), 128'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk_i); #1;
          chk("rst_no_done", 128'(kif.done_o), 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_stay_idle", 128'(kif.busy_o), 128'd0);
        return;
      end
      if (kif.out_valid_o) begin
        if (kif.out_ready_i) begin
          if (n_got < 11) begin
            got_key[n_got] = kif.key_round_o;
            got_rnd[n_got] = kif.round_o;
          end
          n_got++;
          if (kif.round_o == 4'd0) fin = 1;
        end else begin
          held = 1;
          hk   = kif.key_round_o;
          hr   = kif.round_o;
        end
      end
      @(posedge clk_i); #1;
      kif.start_i = 1'b0;
      cyc++;
    end
    if (!fin) begin
      chk("walk_timeout", 128'd0, 128'd1);
    end else begin
      chk("done_pulse", 128'(kif.done_o), 128'd1);
      chk("valid_after_walk", 128'(kif.out_valid_o), 128'd0);
      @(posedge clk_i); #1;
      chk("done_one_cycle", 128'(kif.done_o), 128'd0);
      chk("idle_after_done", 128'(kif.busy_o), 128'd0);
    end
  endtask

  task automatic check_sequence(input string tag);
    chk({tag, "_count"}, 128'(n_got), 128'd11);
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_rnd"}, 128'(got_rnd[i]), 128'(10 - i));
      chk({tag, "_key"}, got_key[i], exp_rk[10 - i]);
    end
  endtask

  localparam logic [127:0] K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  initial begin
    logic [127:0] rkey;
    kif.start_i     = 1'b0;
    kif.key_last_i  = '0;
    kif.out_ready_i = 1'b0;
    build_sbox();

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_valid", 128'(kif.out_valid_o), 128'd0);
    chk("reset_key", kif.key_round_o, 128'd0);
    chk("reset_round", 128'(kif.round_o), 128'd0);
    chk("reset_busy", 128'(kif.busy_o), 128'd0);
    chk("reset_done", 128'(kif.done_o), 128'd0);
    rst_n = 1'b1;
    @(posedge clk_i); #1;

    kif.out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      chk("idle_valid", 128'(kif.out_valid_o), 128'd0);
      chk("idle_key", kif.key_round_o, 128'd0);
      chk("idle_round", 128'(kif.round_o), 128'd0);
      chk("idle_busy", 128'(kif.busy_o), 128'd0);
    end

    expand(K0);

    run_walk(K10, 0);
    chk("fips_r10", got_key[0], K10);
    chk("fips_r9", got_key[1], K9);
    chk("fips_r0", got_key[10], K0);
    check_sequence("fips");
    $display("walk fips ready-high: %0d keys, round0 %h", n_got, got_key[10]);

    run_walk(K10, 1);
    check_sequence("bp");
    $display("walk fips backpressure: %0d keys, round0 %h", n_got, got_key[10]);

    run_walk(K10, 2);
    chk("busy_start_r0", got_key[10], K0);
    check_sequence("busy_start");
    $display("walk fips start-while-busy: %0d keys, round0 %h", n_got, got_key[10]);

    run_walk(K10, 3);
    $display("walk fips reset at round 4: %0d keys accepted before reset", n_got);
    run_walk(K10, 0);
    chk("after_rst_first", 128'(got_rnd[0]), 128'd10);
    check_sequence("after_rst");
    $display("walk fips after reset: %0d keys, round0 %h", n_got, got_key[10]);

    for (int t = 0; t < 100; t++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(rkey);
      run_walk(exp_rk[10], 0);
      chk("roundtrip_count", 128'(n_got), 128'd11);
      chk("roundtrip_r0", got_key[10], rkey);
      $display("walk random %0d: key %h round0 %h", t, rkey, got_key[10]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
